// File: rtl/io_spi_target.sv
// io_spi_target: SPI target (slave) with 8-deep RX and TX byte FIFOs behind four dma_io registers.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   dma_io_we/wadr/wdata         register write port (word addresses 0x3C88..0x3C8B)
//   dma_io_radr/radr_en          register read request; data returned one cycle later
//   dma_io_rdata_in/rdata        read data chain: passes rdata_in through unless this block answered
//   spi_sck/spi_csn/spi_mosi     SPI pins from the controller, asynchronous to clk
//   spi_miso/spi_miso_oe         SPI data to the controller and its tri-state enable
//   spi_target_irq               present only when SPI_TARGET_IRQ_EN is defined
//
// Build option SPI_TARGET_IRQ_EN adds the interrupt output and makes MODE[5:4] writable.
module io_spi_target #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_io_we,
   input  logic [15:2] dma_io_wadr,
   input  logic [31:0] dma_io_wdata,
   input  logic [15:2] dma_io_radr,
   input  logic        dma_io_radr_en,
   input  logic [31:0] dma_io_rdata_in,
   output logic [31:0] dma_io_rdata,
   input  logic        spi_sck,
   input  logic        spi_csn,
   input  logic        spi_mosi,
   output logic        spi_miso,
`ifdef SPI_TARGET_IRQ_EN
   output logic        spi_miso_oe,
   output logic        spi_target_irq
`else
   output logic        spi_miso_oe
`endif
);
   localparam logic [15:2] A_MODE = 14'h3C88;
   localparam logic [15:2] A_STAT = 14'h3C89;
   localparam logic [15:2] A_TXD  = 14'h3C8A;
   localparam logic [15:2] A_RXD  = 14'h3C8B;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, csn_sync_q, csn_sync_d, mosi_sync_q, mosi_sync_d;
   logic       sck_s, csn_s, mosi_s, sck_prev_q, sck_prev_d, csn_prev_q, csn_prev_d;
   logic       lead_e, trail_e, smp_e, shf_e;
   state_t     state_q, state_d;
   logic [5:0] mode_q, mode_d;
   logic       ovr_q, ovr_d, unr_q, unr_d;
   logic [7:0] tx_mem_q [8];
   logic [7:0] tx_mem_d [8];
   logic [7:0] rx_mem_q [8];
   logic [7:0] rx_mem_d [8];
   logic [2:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [3:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       rx_push_q, rx_push_d, tx_pend_q, tx_pend_d, hold_q, hold_d;
   logic       miso_q, miso_d, oe_q, oe_d, rd_hit_q, rd_hit_d;
   logic [31:0] rdata_q, rdata_d;
   logic       tx_pop, unr_set, tx_clr, rx_clr, tx_push, tx_do_pop, rx_do_push, rx_do_pop;
   logic       we_mode, we_stat, we_txd, rd_rxd, busy;
   logic       tx_empty, tx_full, rx_empty, rx_full;
   logic [7:0] tx_head, rx_head;
   logic       unused_wdata;
`ifdef SPI_TARGET_IRQ_EN
   logic       irq_q, irq_d;
   assign spi_target_irq = irq_q;
`endif

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign csn_s    = csn_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   // leading edge leaves the CPOL idle level, trailing edge returns to it
   assign lead_e   = mode_q[2] ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s);
   assign trail_e  = mode_q[2] ? (~sck_prev_q & sck_s) : (sck_prev_q & ~sck_s);
   assign smp_e    = mode_q[1] ? trail_e : lead_e;
   assign shf_e    = mode_q[1] ? lead_e : trail_e;
   assign we_mode  = dma_io_we && dma_io_wadr == A_MODE;
   assign we_stat  = dma_io_we && dma_io_wadr == A_STAT;
   assign we_txd   = dma_io_we && dma_io_wadr == A_TXD;
   assign rd_rxd   = dma_io_radr_en && dma_io_radr == A_RXD;
   assign busy     = ~csn_s & mode_q[0];
   assign tx_empty = tx_cnt_q == 4'd0;
   assign tx_full  = tx_cnt_q == 4'd8;
   assign rx_empty = rx_cnt_q == 4'd0;
   assign rx_full  = rx_cnt_q == 4'd8;
   assign tx_head  = tx_mem_q[tx_rp_q];
   assign rx_head  = rx_mem_q[rx_rp_q];
   assign unused_wdata = ^dma_io_wdata[31:12];
   assign spi_miso     = miso_q;
   assign spi_miso_oe  = oe_q;
   assign dma_io_rdata = rd_hit_q ? rdata_q : dma_io_rdata_in;

   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_d  = sck_s;
      csn_prev_d  = csn_s;
      state_d     = state_q;
      mode_d      = mode_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      tx_pend_d   = tx_pend_q;
      hold_d      = hold_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      rx_push_d   = 1'b0;
      tx_pop      = 1'b0;
      unr_set     = 1'b0;
      if (csn_s || state_q == S_IDLE) begin
         state_d   = (!csn_s && csn_prev_q && mode_q[0]) ? S_LOAD : S_IDLE;
         oe_d      = 1'b0;
         bit_cnt_d = 3'd0;
         tx_pend_d = 1'b0;
         hold_d    = 1'b0;
      end else if (state_q == S_LOAD) begin
         tx_pop  = 1'b1;
         unr_set = tx_empty;
         tx_sr_d = tx_empty ? 8'hFF : tx_head;
         miso_d  = mode_q[3] ? tx_sr_d[7] : tx_sr_d[0];
         oe_d    = 1'b1;
         // with CPHA=1 the first shift edge of the first byte must keep the bit LOAD already drove
         hold_d  = mode_q[1];
         state_d = S_SHIFT;
      end else begin
         if (smp_e) begin
            rx_sr_d   = mode_q[3] ? {rx_sr_q[6:0], mosi_s} : {mosi_s, rx_sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_push_d = bit_cnt_q == 3'd7;
            tx_pend_d = tx_pend_q | (bit_cnt_q == 3'd7);
         end
         if (shf_e) begin
            tx_pop    = tx_pend_q;
            unr_set   = tx_pend_q & tx_empty;
            tx_sr_d   = tx_pend_q ? (tx_empty ? 8'hFF : tx_head) :
                        hold_q    ? tx_sr_q :
                        mode_q[3] ? {tx_sr_q[6:0], 1'b0} : {1'b0, tx_sr_q[7:1]};
            miso_d    = mode_q[3] ? tx_sr_d[7] : tx_sr_d[0];
            tx_pend_d = 1'b0;
            hold_d    = 1'b0;
         end
      end
      // FIFO clear beats any push or pop in the same cycle
      tx_clr    = we_stat & dma_io_wdata[11];
      tx_push   = we_txd & ~tx_full;
      tx_do_pop = tx_pop & ~tx_empty;
      tx_mem_d  = tx_mem_q;
      if (tx_push) tx_mem_d[tx_wp_q] = dma_io_wdata[7:0];
      tx_wp_d   = tx_clr ? 3'd0 : tx_wp_q + {2'd0, tx_push};
      tx_rp_d   = tx_clr ? 3'd0 : tx_rp_q + {2'd0, tx_do_pop};
      tx_cnt_d  = tx_clr ? 4'd0 : tx_cnt_q + {3'd0, tx_push} - {3'd0, tx_do_pop};
      rx_clr     = we_stat & dma_io_wdata[10];
      rx_do_push = rx_push_q & ~rx_full;
      rx_do_pop  = rd_rxd & ~rx_empty;
      rx_mem_d   = rx_mem_q;
      if (rx_do_push) rx_mem_d[rx_wp_q] = rx_sr_q;
      rx_wp_d    = rx_clr ? 3'd0 : rx_wp_q + {2'd0, rx_do_push};
      rx_rp_d    = rx_clr ? 3'd0 : rx_rp_q + {2'd0, rx_do_pop};
      rx_cnt_d   = rx_clr ? 4'd0 : rx_cnt_q + {3'd0, rx_do_push} - {3'd0, rx_do_pop};
      ovr_d = (ovr_q & ~(we_stat & dma_io_wdata[8])) | (rx_push_q & rx_full & ~rx_clr);
      unr_d = (unr_q & ~(we_stat & dma_io_wdata[9])) | unr_set;
`ifdef SPI_TARGET_IRQ_EN
      if (we_mode && !busy) mode_d = dma_io_wdata[5:0];
      irq_d = (~rx_empty & mode_q[4]) | ((ovr_q | unr_q) & mode_q[5]);
`else
      if (we_mode && !busy) mode_d = {2'b00, dma_io_wdata[3:0]};
`endif
      rd_hit_d = dma_io_radr_en && dma_io_radr[15:4] == A_MODE[15:4];
      // RXD flags report the occupancy after this read's pop
      rdata_d  = !dma_io_radr_en       ? rdata_q :
                 dma_io_radr == A_MODE ? {26'd0, mode_q} :
                 dma_io_radr == A_STAT ? {22'd0, unr_q, ovr_q, 3'd0, busy, tx_full, tx_empty, rx_full, rx_empty} :
                 dma_io_radr == A_TXD  ? {22'd0, tx_empty, tx_full, 8'd0} :
                                         {22'd0, rx_cnt_d == 4'd0, rx_cnt_d == 4'd8, rx_head};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         csn_sync_q  <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         csn_prev_q  <= 1'b1;
         state_q     <= S_IDLE;
         mode_q      <= 6'h08;
         ovr_q       <= 1'b0;
         unr_q       <= 1'b0;
         tx_mem_q    <= '{default: 8'h00};
         rx_mem_q    <= '{default: 8'h00};
         tx_wp_q     <= 3'd0;
         tx_rp_q     <= 3'd0;
         rx_wp_q     <= 3'd0;
         rx_rp_q     <= 3'd0;
         tx_cnt_q    <= 4'd0;
         rx_cnt_q    <= 4'd0;
         tx_sr_q     <= 8'h00;
         rx_sr_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         rx_push_q   <= 1'b0;
         tx_pend_q   <= 1'b0;
         hold_q      <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         rd_hit_q    <= 1'b0;
         rdata_q     <= 32'd0;
`ifdef SPI_TARGET_IRQ_EN
         irq_q       <= 1'b0;
`endif
      end else begin
         sck_sync_q  <= sck_sync_d;
         csn_sync_q  <= csn_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         csn_prev_q  <= csn_prev_d;
         state_q     <= state_d;
         mode_q      <= mode_d;
         ovr_q       <= ovr_d;
         unr_q       <= unr_d;
         tx_mem_q    <= tx_mem_d;
         rx_mem_q    <= rx_mem_d;
         tx_wp_q     <= tx_wp_d;
         tx_rp_q     <= tx_rp_d;
         rx_wp_q     <= rx_wp_d;
         rx_rp_q     <= rx_rp_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_push_q   <= rx_push_d;
         tx_pend_q   <= tx_pend_d;
         hold_q      <= hold_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         rd_hit_q    <= rd_hit_d;
         rdata_q     <= rdata_d;
`ifdef SPI_TARGET_IRQ_EN
         irq_q       <= irq_d;
`endif
      end
   end
endmodule

// File: tb/tb_io_spi_target.sv
// tb_io_spi_target: directed bench for io_spi_target acting as a bit-banged SPI controller plus bus master.
module tb_io_spi_target;
   localparam int H = 8;
   localparam logic [15:2] A_MODE = 14'h3C88;
   localparam logic [15:2] A_STAT = 14'h3C89;
   localparam logic [15:2] A_TXD  = 14'h3C8A;
   localparam logic [15:2] A_RXD  = 14'h3C8B;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dma_io_we = 1'b0;
   logic [15:2] dma_io_wadr = '0;
   logic [31:0] dma_io_wdata = '0;
   logic [15:2] dma_io_radr = '0;
   logic        dma_io_radr_en = 1'b0;
   logic [31:0] dma_io_rdata_in = 32'hDEADBEEF;
   logic [31:0] dma_io_rdata;
   logic        spi_sck = 1'b0;
   logic        spi_csn = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe;
`ifdef SPI_TARGET_IRQ_EN
   logic        spi_target_irq;
`endif

   always #5 clk = ~clk;

   io_spi_target #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .dma_io_we(dma_io_we), .dma_io_wadr(dma_io_wadr), .dma_io_wdata(dma_io_wdata),
      .dma_io_radr(dma_io_radr), .dma_io_radr_en(dma_io_radr_en),
      .dma_io_rdata_in(dma_io_rdata_in), .dma_io_rdata(dma_io_rdata),
      .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso),
      .spi_miso_oe(spi_miso_oe)
`ifdef SPI_TARGET_IRQ_EN
      , .spi_target_irq(spi_target_irq)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] mo [16];
   logic [7:0] mi [16];
   logic cpol_v = 1'b0, cpha_v = 1'b0, msb_v = 1'b1;
   logic [31:0] rv;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [15:2] a, input logic [31:0] d);
      @(negedge clk);
      dma_io_we = 1'b1; dma_io_wadr = a; dma_io_wdata = d;
      @(negedge clk);
      dma_io_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:2] a, input logic [31:0] exp);
      @(negedge clk);
      dma_io_radr_en = 1'b1; dma_io_radr = a;
      @(negedge clk);
      dma_io_radr_en = 1'b0;
      chk(tag, dma_io_rdata, exp);
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic msb);
      spi_sck = cpol;
      tick(4);
      cpol_v = cpol; cpha_v = cpha; msb_v = msb;
      wr(A_MODE, {28'd0, msb, cpol, cpha, 1'b1});
   endtask

   // CPHA=0 frames raise csn together with the final trailing edge so no extra shift edge is seen
   task automatic frame(input int nbits);
      int p;
      for (int j = 0; j < 16; j++) mi[j] = 8'h00;
      spi_csn = 1'b0;
      tick(2 * H);
      for (int i = 0; i < nbits; i++) begin
         p = msb_v ? 7 - (i % 8) : i % 8;
         if (cpha_v) begin
            spi_sck = ~cpol_v; spi_mosi = mo[i / 8][p];
            tick(H);
            mi[i / 8][p] = spi_miso;
            spi_sck = cpol_v;
            tick(H);
         end else begin
            spi_mosi = mo[i / 8][p];
            tick(H);
            mi[i / 8][p] = spi_miso;
            spi_sck = ~cpol_v;
            tick(H);
            spi_sck = cpol_v;
            if (i == nbits - 1) spi_csn = 1'b1;
         end
      end
      spi_csn = 1'b1;
      tick(2 * H);
   endtask

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(2);
      chk("rst_oe", spi_miso_oe, 0);
      chk("rst_miso", spi_miso, 0);
      chk("passthru", dma_io_rdata, 32'hDEADBEEF);
      rd_chk("rst_mode", A_MODE, 32'h8);
      rd_chk("rst_stat", A_STAT, 32'h5);

      set_mode(1'b0, 1'b0, 1'b1);
      wr(A_TXD, 32'hA5);
      rd_chk("m0_stat_pre", A_STAT, 32'h1);
      mo[0] = 8'h3C;
      frame(8);
      chk("m0_miso", mi[0], 32'hA5);
      rd_chk("m0_rxd", A_RXD, 32'h23C);
      rd_chk("m0_stat", A_STAT, 32'h5);

      set_mode(1'b1, 1'b1, 1'b0);
      wr(A_TXD, 32'h01);
      wr(A_TXD, 32'h80);
      mo[0] = 8'hF0; mo[1] = 8'h0F;
      frame(16);
      chk("m3_miso0", mi[0], 32'h01);
      chk("m3_miso1", mi[1], 32'h80);
      rd_chk("m3_rxd0", A_RXD, 32'h0F0);
      rd_chk("m3_rxd1", A_RXD, 32'h20F);
      rd_chk("m3_stat", A_STAT, 32'h5);

      set_mode(1'b0, 1'b0, 1'b1);
      mo[0] = 8'h11;
      frame(8);
      chk("ur_miso", mi[0], 32'hFF);
      rd_chk("ur_stat", A_STAT, 32'h204);
      wr(A_STAT, 32'h200);
      rd_chk("ur_clr", A_STAT, 32'h004);
      rd_chk("ur_rxd", A_RXD, 32'h211);

      for (int k = 0; k < 9; k++) mo[k] = 8'(8'h10 + k);
      frame(72);
      rd_chk("ov_stat", A_STAT, 32'h306);
      for (int k = 0; k < 8; k++) rd_chk("ov_rxd", A_RXD, (k == 7 ? 32'h200 : 32'h0) | 32'(8'h10 + k));
      rd_chk("ov_empty", A_RXD, 32'h210);
      wr(A_STAT, 32'h300);
      rd_chk("ov_clr", A_STAT, 32'h5);

      wr(A_TXD, 32'hC3);
      mo[0] = 8'hF0;
      frame(4);
      chk("ab_oe0", spi_miso_oe, 0);
      rd_chk("ab_stat", A_STAT, 32'h5);
      mo[0] = 8'h5A;
      frame(8);
      chk("ab_miso", mi[0], 32'hFF);
      chk("ab_oe1", spi_miso_oe, 0);
      rd_chk("ab_rxd", A_RXD, 32'h25A);
      rd_chk("ab_stat2", A_STAT, 32'h205);
      wr(A_STAT, 32'h300);

`ifdef SPI_TARGET_IRQ_EN
      wr(A_MODE, 32'h19);
      rd_chk("irq_mode", A_MODE, 32'h19);
      chk("irq_idle", spi_target_irq, 0);
      mo[0] = 8'h77;
      frame(8);
      chk("irq_set", spi_target_irq, 1);
      rd_chk("irq_rxd", A_RXD, 32'h277);
      chk("irq_hold", spi_target_irq, 1);
      tick(1);
      chk("irq_fall", spi_target_irq, 0);
      wr(A_MODE, 32'h09);
      wr(A_STAT, 32'h300);
`else
      wr(A_MODE, 32'h39);
      rd_chk("mode_hi", A_MODE, 32'h09);
`endif

      for (int k = 0; k < 9; k++) wr(A_TXD, 32'(k));
      rd_chk("txf_stat", A_STAT, 32'h9);
      rd_chk("txf_txd", A_TXD, 32'h100);
      wr(A_STAT, 32'h800);
      rd_chk("txf_clr", A_TXD, 32'h200);

      spi_csn = 1'b0;
      tick(2 * H);
      rd_chk("busy_stat", A_STAT, 32'h215);
      wr(A_MODE, 32'h0);
      rd_chk("busy_mode", A_MODE, 32'h9);
      spi_csn = 1'b1;
      tick(H);
      wr(A_MODE, 32'h0);
      rd_chk("idle_mode", A_MODE, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/io_spi_target.md
# io_spi_target

SPI target (slave) peripheral on the IO bus, the receiving end of an SPI link driven by an external controller. It samples `spi_mosi` on the controller's `spi_sck` while `spi_csn` is low and pushes each received byte into an 8-deep RX FIFO. It shifts bytes from an 8-deep TX FIFO out on `spi_miso`. The CPU loads and drains both FIFOs through four registers on the `dma_io` bus, placed directly after the SPI controller registers.

## Interface
- `SYNC_STAGES`, 2: flop stages on each SPI input (minimum 2).
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `dma_io_we`  in  1: bus write strobe.
- `dma_io_wadr`  in  [15:2]: write word address.
- `dma_io_wdata`  in  32: write data.
- `dma_io_radr`  in  [15:2]: read word address.
- `dma_io_radr_en`  in  1: read strobe.
- `dma_io_rdata_in`  in  32: read data from upstream, passed through when not addressed.
- `dma_io_rdata`  out  32: read data out.
- `spi_sck`  in  1: clock from the controller, asynchronous to `clk`.
- `spi_csn`  in  1: chip select, active-low, asynchronous.
- `spi_mosi`  in  1: data from the controller.
- `spi_miso`  out  1: data to the controller. Reset value 0.
- `spi_miso_oe`  out  1: tri-state enable for `spi_miso`. Reset value 0.

## Operation
Registers, by word address:
- **MODE, 0x3C88** (reset 0x8)
  - [0] enable. [1] CPHA. [2] CPOL. [3] MSB-first (0 = LSB-first).
  - Writes to MODE take effect only while idle. They are ignored while `busy` = 1.
- **STAT, 0x3C89**
  - Read: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] busy (synchronized `csn` is low and enable = 1), [8] overrun (sticky), [9] underrun (sticky).
  - Write 1 to [8] or [9] clears that flag.
  - Write 1 to [10] empties the RX FIFO. Write 1 to [11] empties the TX FIFO.
- **TXD, 0x3C8A**
  - Write [7:0] pushes one byte to the TX FIFO. The write is dropped if the FIFO is full.
  - Read returns {22'd0, tx_empty, tx_full, 8'd0}.
- **RXD, 0x3C8B**
  - Read returns {22'd0, rx_empty, rx_full, head byte}, then pops one entry.
  - A read while empty returns the stale head and does not pop.

Input path: `spi_sck`, `spi_csn` and `spi_mosi` each pass through `SYNC_STAGES` flops. `sck` is then registered once more for edge detection.

Edge definitions:
- Leading edge is the transition away from the CPOL level; trailing edge is the transition back.
- Sample edge: leading when CPHA = 0, trailing when CPHA = 1.
- Shift edge is the other of the two.

State machine:
- **IDLE**
  - `spi_miso_oe` = 0. Bit counter = 0.
  - On a synchronized falling edge of `csn` with enable = 1, go to LOAD.
- **LOAD** (one cycle)
  - Pop the TX FIFO into the shift register.
  - If the TX FIFO is empty, load 0xFF and set underrun.
  - Drive the first bit on `spi_miso` and assert `spi_miso_oe`. Go to SHIFT.
- **SHIFT**
  - On each sample edge: shift the synchronized `mosi` into the RX shift register and increment the 3-bit counter.
  - On each shift edge: drive the next TX bit.
  - On the 8th sample, the completed byte is pushed to the RX FIFO one cycle later. If the RX FIFO is full, the byte is dropped and overrun is set. The counter wraps to 0.
  - The next TX byte is popped on the following shift edge (0xFF plus underrun if empty). For CPHA = 1 the first shift edge of every byte performs this pop.
- **Return to IDLE**
  - A `csn` rise in any state returns to IDLE immediately.
  - A partial RX byte is discarded, with no push and no flag.
  - A partially sent TX byte is lost; it is not re-queued.

Bit order: MSB-first sends and assembles bit 7 first; LSB-first uses bit 0 first.

Simultaneous events:
- Bus push and SPI pop on the same FIFO in the same cycle: the occupancy count is unchanged.
- Bus reset-FIFO and push in the same cycle: the reset wins.

## Timing
- Register reads: `dma_io_rdata` is valid exactly 1 cycle after `dma_io_radr_en`. The RXD pop occurs in that same cycle. All other cycles pass `dma_io_rdata_in` through.
- Register writes take effect on the next clock edge.
- SPI input latency: input pin change to internal edge detect is `SYNC_STAGES` + 1 cycles.
- `spi_miso` updates `SYNC_STAGES` + 2 cycles after the shift edge at the pin.
- Supported rate: each `sck` half-period must be at least `SYNC_STAGES` + 3 `clk` cycles, i.e. `clk` at 10x `sck` or more with the default.
- Reset mid-transfer: everything returns to reset values, FIFOs are empty, and the state is IDLE.

## Configuration
- **`SPI_TARGET_IRQ_EN` defined**
  - Adds output `spi_target_irq` (1 bit, reset 0), registered.
  - `spi_target_irq` = (~rx_empty & MODE[4]) | ((overrun | underrun) & MODE[5]).
  - MODE[5:4] are writable and readable.
- **Not defined**
  - The port is absent.
  - MODE[5:4] read 0 and writes to them are ignored.

## Test plan
- Mode 0 (CPOL 0, CPHA 0), MSB-first, TX preloaded 0xA5. Controller sends 0x3C with `sck` = `clk`/16 -> the controller receives 0xA5, RXD reads 0x23C (rx_empty = 1 after the pop), STAT[8:9] = 0.
- Mode 3 (CPOL 1, CPHA 1), LSB-first, TX preloaded 0x01, 0x80. Controller sends two bytes 0xF0, 0x0F -> the controller receives 0x01, 0x80; RXD reads give 0xF0 then 0x0F.
- TX FIFO empty, controller sends one byte -> `spi_miso` carries 0xFF, STAT[9] = 1; writing 0x200 to STAT clears it.
- Controller sends 9 bytes without any CPU reads -> 8 bytes are held, STAT[1] = 1, STAT[8] = 1, and the 9th byte is absent.
- `csn` rises after 4 bits, then a full byte 0x5A is sent -> only 0x5A appears in the RX FIFO and `spi_miso_oe` = 0 between frames.
- With `SPI_TARGET_IRQ_EN`, MODE[4] = 1: one received byte -> `spi_target_irq` = 1, and it falls the cycle after the RXD read that empties the FIFO.
